// File: rtl/instr_encoder.sv
// Instruction encoder and program loader: turns symbolic instruction requests
// into 32-bit MIPS words and writes them sequentially into instruction memory.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [2:0] K_RFMT = 3'd0;
  localparam logic [2:0] K_LW   = 3'd1;
  localparam logic [2:0] K_SW   = 3'd2;
  localparam logic [2:0] K_BEQ  = 3'd3;
  localparam logic [2:0] K_BNE  = 3'd4;
  localparam logic [2:0] K_J    = 3'd5;
  localparam logic [2:0] K_ADDI = 3'd6;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata;
  logic              r_full;
  logic              r_err;

  logic [15:0]       w_offset;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_countInc;

  // Branch offset is relative to the slot after the one being written (count+1).
  assign w_offset   = in_imm - 16'(r_count) - 16'd1;
  assign w_countInc = r_count + (ADDR_W+1)'(1);

  always_comb begin
    w_word = 32'd0;
    case (in_kind)
      K_RFMT:  w_word = {6'd0,  in_rs, in_rt, in_rd, 5'd0, in_funct};
      K_LW:    w_word = {6'd35, in_rs, in_rt, in_imm};
      K_SW:    w_word = {6'd43, in_rs, in_rt, in_imm};
      K_BEQ:   w_word = {6'd4,  in_rs, in_rt, w_offset};
      K_BNE:   w_word = {6'd5,  in_rs, in_rt, w_offset};
      K_J:     w_word = {6'd2,  in_target};
      K_ADDI:  w_word = {6'd8,  in_rs, in_rt, in_imm};
      default: w_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_wdata <= 32'd0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (in_kind == 3'd7) begin
              r_err <= 1'b1;
            end else begin
              r_wdata <= w_word;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            r_count <= w_countInc;
            if (w_countInc == DEPTH) begin
              r_state <= S_FULL;
              r_full  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_FULL: begin
          r_state <= S_FULL;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign mem_we    = (r_state == S_WRITE);
  assign mem_addr  = r_count[ADDR_W-1:0];
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign full      = r_full;
  assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: expected memory writes are queued when
// a request is accepted and compared when the encoder presents an acknowledged write.
module tb_instr_encoder;

  localparam int ADDR_W = 6;

  logic              clk;
  logic              reset_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int vectors = 0;
  int miscompares = 0;
  int pushed = 0;
  logic [37:0] expQ[$];

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .full(full), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Independent reference encoder, offset done in 17-bit arithmetic.
  function automatic logic [31:0] modelEncode(input logic [2:0] kind, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] funct,
      input logic [15:0] imm, input logic [25:0] target, input int cnt);
    logic [16:0] off;
    logic [31:0] base;
    off  = {1'b0, imm} - 17'(cnt + 1);
    base = (32'(rs) << 21) | (32'(rt) << 16);
    case (kind)
      3'd0: return base | (32'(rd) << 11) | 32'(funct);
      3'd1: return (32'd35 << 26) | base | 32'(imm);
      3'd2: return (32'd43 << 26) | base | 32'(imm);
      3'd3: return (32'd4 << 26) | base | 32'(off[15:0]);
      3'd4: return (32'd5 << 26) | base | 32'(off[15:0]);
      3'd5: return (32'd2 << 26) | 32'(target);
      default: return (32'd8 << 26) | base | 32'(imm);
    endcase
  endfunction

  // Scoreboard side: an acknowledged write commits at the next rising edge.
  always @(negedge clk) begin
    if (mem_we && mem_ack && reset_n && !clear) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        logic [37:0] e;
        e = expQ.pop_front();
        checkOutput("mem_addr", 32'(mem_addr), 32'(e[37:32]));
        checkOutput("mem_wdata", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
      input logic [25:0] target, input logic [31:0] expWord);
    int n = 0;
    logic accepted = 1'b0;
    logic rdy;
    in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = funct; in_imm = imm; in_target = target;
    in_valid = 1'b1;
    while (!accepted && n < 50) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) accepted = 1'b1;
      n++;
    end
    in_valid = 1'b0;
    if (accepted) begin
      expQ.push_back({6'(pushed), expWord});
      pushed++;
    end else begin
      checkOutput("accept timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(in_ready || full) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) checkOutput("idle timeout", 32'd0, 32'd1);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    expQ.delete();
    pushed = 0;
  endtask

  initial begin
    logic [2:0] k;
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    logic [15:0] im;
    logic [25:0] tg;
    logic [31:0] stallWord;

    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; mem_ack = 1'b1;
    in_kind = 3'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
    in_funct = 6'd0; in_imm = 16'd0; in_target = 26'd0;
    @(posedge clk); #1;
    doReset();

    checkOutput("rst mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst count", 32'(count), 32'd0);
    checkOutput("rst full", 32'(full), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    checkOutput("rst in_ready", 32'(in_ready), 32'd1);

    applyStimulus(3'd0, 5'd1, 5'd2, 5'd3, 6'd32, 16'd0, 26'd0, 32'h0022_1820);
    checkOutput("rfmt latency mem_we", 32'(mem_we), 32'd1);
    waitIdle();
    checkOutput("rfmt count", 32'(count), 32'd1);

    doReset();
    applyStimulus(3'd1, 5'd9, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0, 32'h8D28_0004);
    applyStimulus(3'd6, 5'd0, 5'd5, 5'd0, 6'd0, 16'd7, 26'd0, 32'h2005_0007);
    applyStimulus(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 32'h0800_0010);
    applyStimulus(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'd0, 26'd0, 32'h1022_FFFC);
    applyStimulus(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'd6, 26'd0, 32'h1422_0001);
    waitIdle();
    checkOutput("seq count", 32'(count), 32'd5);
    checkOutput("seq drained", 32'(expQ.size()), 32'd0);

    mem_ack = 1'b0;
    stallWord = 32'h2064_1234;
    applyStimulus(3'd6, 5'd3, 5'd4, 5'd0, 6'd0, 16'h1234, 26'd0, stallWord);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall mem_we", 32'(mem_we), 32'd1);
      checkOutput("stall mem_addr", 32'(mem_addr), 32'd5);
      checkOutput("stall mem_wdata", mem_wdata, stallWord);
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall count", 32'(count), 32'd5);
      @(posedge clk); #1;
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    checkOutput("ack count", 32'(count), 32'd6);
    checkOutput("ack in_ready", 32'(in_ready), 32'd1);

    in_kind = 3'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("illegal err", 32'(err), 32'd1);
    checkOutput("illegal mem_we", 32'(mem_we), 32'd0);
    checkOutput("illegal in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("illegal err pulse", 32'(err), 32'd0);
    checkOutput("illegal count", 32'(count), 32'd6);

    doReset();
    for (int i = 0; i < 64; i++) begin
      k  = 3'($urandom_range(0, 6));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      fn = 6'($urandom); im = 16'($urandom); tg = 26'($urandom);
      applyStimulus(k, rs, rt, rd, fn, im, tg, modelEncode(k, rs, rt, rd, fn, im, tg, pushed));
    end
    waitIdle();
    checkOutput("fill full", 32'(full), 32'd1);
    checkOutput("fill count", 32'(count), 32'd64);
    checkOutput("fill in_ready", 32'(in_ready), 32'd0);
    in_kind = 3'd0; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("full ignores mem_we", 32'(mem_we), 32'd0);
      checkOutput("full ignores count", 32'(count), 32'd64);
    end
    clear = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    checkOutput("clear count", 32'(count), 32'd0);
    checkOutput("clear in_ready", 32'(in_ready), 32'd1);
    checkOutput("clear full", 32'(full), 32'd0);
    pushed = 0;

    mem_ack = 1'b0;
    applyStimulus(3'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010, 26'd0, 32'h8C43_0010);
    clear = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checkOutput("clear-vs-ack mem_we", 32'(mem_we), 32'd0);
    checkOutput("clear-vs-ack count", 32'(count), 32'd0);
    expQ.delete();
    pushed = 0;

    mem_ack = 1'b0;
    applyStimulus(3'd0, 5'd4, 5'd5, 5'd6, 6'd34, 16'd0, 26'd0, 32'h0085_3022);
    checkOutput("pre-rst mem_we", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkOutput("rst-in-write mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst-in-write count", 32'(count), 32'd0);
    expQ.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
